// File: rtl/AHB_package.sv
// Shared AHB bus types: transfer kinds, slave responses and default-slave FSM states.
package AHB_package;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_type;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } defslv_state_type;

  // NONSEQ and SEQ are the only transfer types that carry a real access.
  function automatic logic is_active_trans(input htrans_type t);
    logic act;
    case (t)
      NONSEQ:  act = 1'b1;
      SEQ:     act = 1'b1;
      default: act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ahb_err_logger.sv
// First-fault capture registers plus a saturating count of every faulting access.
import AHB_package::*;

module ahb_err_logger #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              accept,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              err_clr,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_write,
  output logic [2:0]        err_size,
  output logic [CNT_W-1:0]  err_cnt
);

  logic              valid_r, valid_nxt_s, valid_base_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s, addr_base_s;
  logic              write_r, write_nxt_s, write_base_s;
  logic [2:0]        size_r, size_nxt_s, size_base_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_base_s;

  // Clear is applied before capture so a same-cycle fault starts a fresh log.
  always_comb begin
    valid_base_s = valid_r;
    addr_base_s  = addr_r;
    write_base_s = write_r;
    size_base_s  = size_r;
    cnt_base_s   = cnt_r;
    if (err_clr) begin
      valid_base_s = 1'b0;
      addr_base_s  = {ADDR_W{1'b0}};
      write_base_s = 1'b0;
      size_base_s  = 3'b000;
      cnt_base_s   = {CNT_W{1'b0}};
    end else begin
      valid_base_s = valid_r;
    end

    valid_nxt_s = valid_base_s;
    addr_nxt_s  = addr_base_s;
    write_nxt_s = write_base_s;
    size_nxt_s  = size_base_s;
    cnt_nxt_s   = cnt_base_s;
    if (accept) begin
      if (!valid_base_s) begin
        valid_nxt_s = 1'b1;
        addr_nxt_s  = haddr;
        write_nxt_s = hwrite;
        size_nxt_s  = hsize;
      end else begin
        valid_nxt_s = valid_base_s;
      end
      if (cnt_base_s == {CNT_W{1'b1}}) begin
        cnt_nxt_s = cnt_base_s;
      end else begin
        cnt_nxt_s = cnt_base_s + CNT_W'(1'b1);
      end
    end else begin
      cnt_nxt_s = cnt_base_s;
    end
  end

  // Log state registers.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      valid_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      write_r <= 1'b0;
      size_r  <= 3'b000;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      valid_r <= valid_nxt_s;
      addr_r  <= addr_nxt_s;
      write_r <= write_nxt_s;
      size_r  <= size_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign err_valid = valid_r;
  assign err_addr  = addr_r;
  assign err_write = write_r;
  assign err_size  = size_r;
  assign err_cnt   = cnt_r;

endmodule

// File: rtl/ahb_default_slave.sv
// AHB default slave: two-cycle ERROR for unmapped NONSEQ/SEQ, zero-wait OKAY otherwise.
// Optional first-fault logger enabled by defining AHB_DEFSLV_ERR_LOG_EN.
import AHB_package::*;

module ahb_default_slave #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  htrans_type                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic                      hready,
  output logic                      hreadyout,
  output hresp_type                 hresp,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  input  logic                      err_clr,
  output logic                      err_valid,
  output logic [AHB_ADDR_WIDTH-1:0] err_addr,
  output logic                      err_write,
  output logic [2:0]                err_size,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);

  defslv_state_type state_r, next_state_s;
  logic             accept_s;
  logic             hreadyout_r, hreadyout_nxt_s;
  hresp_type        hresp_r, hresp_nxt_s;

  assign accept_s = hsel & hready & is_active_trans(htrans);

  // Next state, with bus outputs decoded from the state being entered.
  always_comb begin
    next_state_s    = state_r;
    hreadyout_nxt_s = 1'b1;
    hresp_nxt_s     = OKAY;
    case (state_r)
      DS_IDLE: begin
        if (accept_s) begin
          next_state_s = DS_ERR1;
        end else begin
          next_state_s = DS_IDLE;
        end
      end
      DS_ERR1: next_state_s = DS_ERR2;
      DS_ERR2: begin
        if (accept_s) begin
          next_state_s = DS_ERR1;
        end else begin
          next_state_s = DS_IDLE;
        end
      end
      default: next_state_s = DS_IDLE;
    endcase

    case (next_state_s)
      DS_ERR1: begin
        hreadyout_nxt_s = 1'b0;
        hresp_nxt_s     = ERROR;
      end
      DS_ERR2: begin
        hreadyout_nxt_s = 1'b1;
        hresp_nxt_s     = ERROR;
      end
      default: begin
        hreadyout_nxt_s = 1'b1;
        hresp_nxt_s     = OKAY;
      end
    endcase
  end

  // State and registered bus response; the outputs track the state one-for-one.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_r     <= DS_IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= OKAY;
    end else begin
      state_r     <= next_state_s;
      hreadyout_r <= hreadyout_nxt_s;
      hresp_r     <= hresp_nxt_s;
    end
  end

  assign hreadyout = hreadyout_r;
  assign hresp     = hresp_r;
  assign hrdata    = {AHB_DATA_WIDTH{1'b0}};

`ifdef AHB_DEFSLV_ERR_LOG_EN
  ahb_err_logger #(
    .ADDR_W (AHB_ADDR_WIDTH),
    .CNT_W  (ERR_CNT_WIDTH)
  ) u_err_logger (
    .hclk      (hclk),
    .hreset    (hreset),
    .accept    (accept_s),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .err_clr   (err_clr),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_write (err_write),
    .err_size  (err_size),
    .err_cnt   (err_cnt)
  );
`else
  // Logger absent: capture inputs are intentionally left unconsumed.
  logic unused_log_inputs_s;
  assign unused_log_inputs_s = ^{haddr, hwrite, hsize, err_clr};
  assign err_valid = 1'b0;
  assign err_addr  = {AHB_ADDR_WIDTH{1'b0}};
  assign err_write = 1'b0;
  assign err_size  = 3'b000;
  assign err_cnt   = {ERR_CNT_WIDTH{1'b0}};
`endif

endmodule
